// File: rtl/wormux_pkg.sv
// Shared constants and helpers for the wormux arbiter and its checkers.
package wormux_pkg;

    localparam int WORMUX_WIDTH_DEFAULT = 32;
    localparam int WORMUX_DEPTH_DEFAULT = 10;

    // True when at most one bit of vec is set (zero-extend narrower vectors).
    function automatic logic onehot_ok(input logic [31:0] vec);
        return ((vec & (vec - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/wormux_rr_pick.sv
// Combinational round-robin pick: first set req bit scanning circularly from ptr+1,
// done as a priority scan over {req, req-with-indices-up-to-ptr-masked}.
module wormux_rr_pick
    import wormux_pkg::*;
#(
    parameter int DEPTH = WORMUX_DEPTH_DEFAULT,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [DEPTH-1:0] pick,
    output logic [IDX_W-1:0] pick_idx
);

    logic [DEPTH-1:0]   lo_mask;
    logic [2*DEPTH-1:0] dbl_req;
    logic               found;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mask
            assign lo_mask[gi] = (IDX_W'(gi) <= ptr);
        end
    endgenerate

    // Lower copy holds only indices above ptr; upper copy supplies the wrap.
    assign dbl_req = {req, req & ~lo_mask};

    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        pick     = '0;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            if (!found && dbl_req[i]) begin
                found    = 1'b1;
                pick_idx = (i >= DEPTH) ? IDX_W'(i - DEPTH) : IDX_W'(i);
            end
        end
        if (found) begin
            pick[pick_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/wormux_arb.sv
// Round-robin arbiter with registered one-hot-or-zero output stage for the wired-OR mux.
// Optional packet lock (hold the winner until req_last) enabled by WORMUX_ARB_LOCK_EN.
module wormux_arb
    import wormux_pkg::*;
#(
    parameter int WIDTH = WORMUX_WIDTH_DEFAULT,
    parameter int DEPTH = WORMUX_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DEPTH-1:0]         req,
    input  logic [DEPTH-1:0]         req_last,
    input  logic [WIDTH*DEPTH-1:0]   req_data,
    output logic [DEPTH-1:0]         gnt,
    output logic [DEPTH-1:0]         en,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDX_W-1:0] ptr_reg;
    logic             out_valid_reg;
    logic [DEPTH-1:0] en_reg;
    logic [WIDTH-1:0] out_data_reg;

    logic             load;
    logic [DEPTH-1:0] elig_req;
    logic [DEPTH-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic             win;
    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] masked_word [DEPTH];

`ifdef WORMUX_ARB_LOCK_EN
    logic             lock_vld_reg;
    logic [IDX_W-1:0] lock_idx_reg;
    logic [DEPTH-1:0] lock_mask;

    always_comb begin
        lock_mask = '0;
        lock_mask[lock_idx_reg] = 1'b1;
    end

    // While locked only the locked index may compete; others simply wait.
    assign elig_req = lock_vld_reg ? (req & lock_mask) : req;
`else
    logic unused_req_last;
    assign unused_req_last = ^req_last;
    assign elig_req        = req;
`endif

    assign load = !out_valid_reg || out_ready;
    assign win  = |elig_req;

    wormux_rr_pick #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (elig_req),
        .ptr      (ptr_reg),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // AND-OR select keeps the data path free of a binary-indexed mux.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign masked_word[gi] = pick[gi] ? req_data[WIDTH*gi +: WIDTH] : '0;
        end
    endgenerate

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_word = sel_word | masked_word[i];
        end
    end

    assign gnt = (!rst && load && win) ? pick : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            en_reg        <= '0;
            out_data_reg  <= '0;
            ptr_reg       <= IDX_W'(DEPTH - 1);
`ifdef WORMUX_ARB_LOCK_EN
            lock_vld_reg  <= 1'b0;
            lock_idx_reg  <= '0;
`endif
        end else if (load) begin
            if (win) begin
                out_valid_reg <= 1'b1;
                en_reg        <= pick;
                out_data_reg  <= sel_word;
                ptr_reg       <= pick_idx;
`ifdef WORMUX_ARB_LOCK_EN
                lock_vld_reg  <= !req_last[pick_idx];
                lock_idx_reg  <= pick_idx;
`endif
            end else begin
                out_valid_reg <= 1'b0;
                en_reg        <= '0;
                out_data_reg  <= '0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign en        = en_reg;
    assign out_data  = out_data_reg;

endmodule
